// File: rtl/stream_demux1_4_if.sv
// Bundles the producer stream (with destination select) and the four consumer streams of the 1:4 dispatcher.
// Latency: none, wiring only.
// Backpressure: in_ready throttles the producer; out_ready[i] throttles consumer i.
// Ports: in_valid/in_ready/in_data/in_sel is the producer side.
//        out_valid/out_ready/out_data holds four lanes, lane i at [i*WIDTH +: WIDTH].
//        master = traffic source/sink around the dispatcher; slave = the dispatcher.
interface stream_demux1_4_if #(
    parameter int WIDTH = 8
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic [3:0]         out_valid;
    logic [3:0]         out_ready;
    logic [4*WIDTH-1:0] out_data;

    modport master (
        output in_valid, in_data, in_sel, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_sel, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/stream_demux1_4.sv
// Registered 1:4 stream dispatcher: routes each beat to channel in_sel through a per-channel single-entry buffer.
// Latency: one cycle; a beat accepted at edge N shows on out_* right after N. Full rate per channel.
// Backpressure: a beat is refused only when its own channel is full and not draining; other channels are unaffected.
// Ports: clk, rst (synchronous, active high), bus (slave side of stream_demux1_4_if).
//        cnt_out: per-channel saturating accepted-beat counters, present only when STREAM_DEMUX_CNT_EN is defined.
module stream_demux1_4 #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    stream_demux1_4_if.slave        bus
`ifdef STREAM_DEMUX_CNT_EN
    ,
    output logic [4*CNT_W-1:0]      cnt_out
`endif
);

    if (WIDTH < 1 || CNT_W < 1) begin : g_bad_param
        $error("stream_demux1_4: WIDTH and CNT_W must be at least 1");
    end

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } chan_state_e;

    chan_state_e      state_q [4];
    chan_state_e      state_d [4];
    logic [WIDTH-1:0] data_q  [4];
    logic [WIDTH-1:0] data_d  [4];
    logic             in_ready_c;
    logic             accept;
    logic [3:0]       load;

    // Next state per channel. A load wins over a drain on the same edge, which
    // is what keeps a channel full (and at full rate) when it is read and
    // refilled together.
    always_comb begin
        in_ready_c = (state_q[bus.in_sel] == EMPTY) || bus.out_ready[bus.in_sel];
        accept     = bus.in_valid && in_ready_c;
        load       = '0;
        for (int i = 0; i < 4; i++) begin
            state_d[i] = state_q[i];
            data_d[i]  = data_q[i];
            load[i]    = accept && (bus.in_sel == 2'(i));
            if (load[i]) begin
                state_d[i] = FULL;
                data_d[i]  = bus.in_data;
            end else if (state_q[i] == FULL && bus.out_ready[i]) begin
                state_d[i] = EMPTY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= EMPTY;
                data_q[i]  <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                state_q[i] <= state_d[i];
                data_q[i]  <= data_d[i];
            end
        end
    end

    // Outputs come straight from the buffer registers; in_ready is the only
    // combinational output and it never looks at in_valid.
    always_comb begin
        bus.in_ready  = in_ready_c;
        bus.out_valid = '0;
        bus.out_data  = '0;
        for (int i = 0; i < 4; i++) begin
            bus.out_valid[i]                 = (state_q[i] == FULL);
            bus.out_data[i*WIDTH +: WIDTH]   = data_q[i];
        end
    end

`ifdef STREAM_DEMUX_CNT_EN
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];

    // Counters stick at all-ones rather than wrapping.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = cnt_q[i];
            if (load[i] && (cnt_q[i] != {CNT_W{1'b1}})) begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_comb begin
        cnt_out = '0;
        for (int i = 0; i < 4; i++) begin
            cnt_out[i*CNT_W +: CNT_W] = cnt_q[i];
        end
    end
`endif

endmodule

// File: tb/tb_stream_demux1_4.sv
module tb_stream_demux1_4;

    localparam int WIDTH = 8;
`ifdef STREAM_DEMUX_CNT_EN
    localparam int CNT_W = 2;
`else
    localparam int CNT_W = 8;
`endif

    logic clk;
    logic rst;

    stream_demux1_4_if #(.WIDTH(WIDTH)) bus ();

`ifdef STREAM_DEMUX_CNT_EN
    logic [4*CNT_W-1:0] cnt_out;
`endif

    stream_demux1_4 #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus)
`ifdef STREAM_DEMUX_CNT_EN
        ,
        .cnt_out (cnt_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: each channel is a queue that holds at most one beat.
    // A beat is taken when its queue is empty or is being read this edge.
    logic [WIDTH-1:0] mq   [4][$];
    logic [WIDTH-1:0] last [4];
    int               mcnt [4];
    bit               model_on = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            model_on = 1'b1;
            for (int i = 0; i < 4; i++) begin
                mq[i].delete();
                last[i] = '0;
                mcnt[i] = 0;
            end
        end else if (model_on) begin
            int  s;
            bit  take;
            s    = int'(bus.in_sel);
            take = bus.in_valid && (mq[s].size() == 0 || bus.out_ready[s]);
            for (int i = 0; i < 4; i++) begin
                if (mq[i].size() != 0 && bus.out_ready[i]) void'(mq[i].pop_front());
            end
            if (take) begin
                mq[s].push_back(bus.in_data);
                last[s] = bus.in_data;
                if (mcnt[s] < (1 << CNT_W) - 1) mcnt[s]++;
            end
        end
    end

    // Every beat that actually leaves the DUT, as {channel, data}.
    int delivered [$];
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.out_valid[i] && bus.out_ready[i])
                    delivered.push_back((i << 8) | int'(bus.out_data[i*WIDTH +: WIDTH]));
            end
        end
    end

    always @(negedge clk) begin
        if (model_on && !rst) begin
            int s;
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("model_valid%0d", i), 32'(bus.out_valid[i]), 32'(mq[i].size() != 0));
                chk($sformatf("model_data%0d", i), 32'(bus.out_data[i*WIDTH +: WIDTH]), 32'(last[i]));
`ifdef STREAM_DEMUX_CNT_EN
                chk($sformatf("model_cnt%0d", i), 32'(cnt_out[i*CNT_W +: CNT_W]), 32'(mcnt[i]));
`endif
            end
            s = int'(bus.in_sel);
            chk("model_in_ready", 32'(bus.in_ready), 32'(mq[s].size() == 0 || bus.out_ready[s]));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [1:0] s);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.in_sel   = s;
    endtask

    function automatic logic [7:0] odat(input int ch);
        return bus.out_data[ch*WIDTH +: WIDTH];
    endfunction

    int exp_deliv [9] = '{'h0A0, 'h1A1, 'h2A2, 'h3A3, 'h177, 'h255, 'h310, 'h311, 'h312};

    initial begin
        rst = 1'b1;
        bus.out_ready = 4'hF;
        drive(1'b1, 8'hEE, 2'd0);
        cyc();
        cyc();
        rst = 1'b0;
        drive(1'b0, 8'h00, 2'd0);
        #1;
        chk("rst_valid", 32'(bus.out_valid), 32'h0);
        chk("rst_data", bus.out_data, 32'h0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'h1);

        // Basic routing, one beat per channel on consecutive cycles.
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 8'hA0 + 8'(k), 2'(k));
            cyc();
            chk($sformatf("route_valid%0d", k), 32'(bus.out_valid), 32'(1 << k));
            chk($sformatf("route_data%0d", k), 32'(odat(k)), 32'h0A0 + 32'(k));
        end
        drive(1'b0, 8'h00, 2'd0);
        cyc();
        chk("route_drained", 32'(bus.out_valid), 32'h0);

        // Back-pressure on channel 2; channel 1 must still flow.
        bus.out_ready = 4'b1011;
        drive(1'b1, 8'h55, 2'd2);
        #1;
        chk("bp_ready_first", 32'(bus.in_ready), 32'h1);
        cyc();
        chk("bp_valid_55", 32'(bus.out_valid), 32'b0100);
        chk("bp_data_55", 32'(odat(2)), 32'h55);
        drive(1'b1, 8'h66, 2'd2);
        #1;
        chk("bp_refuse_66", 32'(bus.in_ready), 32'h0);
        cyc();
        chk("bp_hold_55", 32'(odat(2)), 32'h55);
        drive(1'b1, 8'h77, 2'd1);
        #1;
        chk("bp_other_ready", 32'(bus.in_ready), 32'h1);
        cyc();
        chk("bp_valid_77", 32'(bus.out_valid), 32'b0110);
        chk("bp_data_77", 32'(odat(1)), 32'h77);
        chk("bp_still_55", 32'(odat(2)), 32'h55);
        drive(1'b0, 8'h00, 2'd0);
        cyc();
        chk("bp_ch1_drained", 32'(bus.out_valid), 32'b0100);
        bus.out_ready = 4'hF;
        cyc();
        chk("bp_ch2_drained", 32'(bus.out_valid), 32'h0);

        // Back-to-back beats into channel 3 while it drains every cycle.
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 8'h10 + 8'(k), 2'd3);
            #1;
            chk($sformatf("dl_ready%0d", k), 32'(bus.in_ready), 32'h1);
            cyc();
            chk($sformatf("dl_valid%0d", k), 32'(bus.out_valid), 32'b1000);
            chk($sformatf("dl_data%0d", k), 32'(odat(3)), 32'h10 + 32'(k));
        end
        drive(1'b0, 8'h00, 2'd0);
        cyc();
        chk("dl_drained", 32'(bus.out_valid), 32'h0);

        // Reset while channels 0 and 2 are full and stalled.
        bus.out_ready = 4'h0;
        drive(1'b1, 8'h21, 2'd0);
        cyc();
        drive(1'b1, 8'h22, 2'd2);
        cyc();
        drive(1'b0, 8'h00, 2'd0);
        chk("mr_full", 32'(bus.out_valid), 32'b0101);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        chk("mr_valid", 32'(bus.out_valid), 32'h0);
        chk("mr_data", bus.out_data, 32'h0);
        bus.out_ready = 4'hF;
        cyc();
        cyc();

        chk("deliv_count", 32'(delivered.size()), 32'd9);
        for (int k = 0; k < 9; k++) begin
            if (k < delivered.size())
                chk($sformatf("deliv%0d", k), 32'(delivered[k]), 32'(exp_deliv[k]));
        end

`ifdef STREAM_DEMUX_CNT_EN
        begin
            int exp_c [5] = '{1, 2, 3, 3, 3};
            for (int k = 0; k < 5; k++) begin
                drive(1'b1, 8'(k), 2'd1);
                cyc();
                chk($sformatf("cnt1_%0d", k), 32'(cnt_out[1*CNT_W +: CNT_W]), 32'(exp_c[k]));
                chk($sformatf("cnt_others_%0d", k),
                    32'({cnt_out[3*CNT_W +: CNT_W], cnt_out[2*CNT_W +: CNT_W], cnt_out[0 +: CNT_W]}), 32'h0);
            end
            drive(1'b0, 8'h00, 2'd0);
            rst = 1'b1;
            cyc();
            rst = 1'b0;
            chk("cnt_rst", 32'(cnt_out), 32'h0);
        end
`endif

        cyc();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
